// File: rtl/sif_pkg.sv
// rtl/sif_pkg.sv - shared helpers for the add/sub result buffer
package sif_pkg;

  // Count values must reach DEPTH itself, hence one bit beyond the address width.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sif_fifo_fwft.sv
// rtl/sif_fifo_fwft.sv - first-word-fall-through FIFO with explicit occupancy and overflow detect
module sif_fifo_fwft
  import sif_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  localparam int CW = cnt_width(DEPTH),
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rd_dat_o,
  output logic [CW-1:0]    occupancy_o,
  output logic             empty_o,
  output logic             full_o,
  output logic             ovf_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    occ_q, occ_d;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (occ_q == CW'(DEPTH));
  assign empty_o = (occ_q == '0);

  // Push is judged against the pre-pop count, so a push at full is dropped
  // even when a pop frees a slot in the same cycle.
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign ovf_o   = push_i & full_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    occ_d    = occ_q + CW'(push_ok) - CW'(pop_ok);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_dat_i;
    end
  end

  assign rd_dat_o    = mem_q[rd_ptr_q];
  assign occupancy_o = occ_q;

endmodule

// File: rtl/sif_addsub_rsltbuf.sv
// rtl/sif_addsub_rsltbuf.sv - credit-gated result buffer presenting a valid/ready stream
module sif_addsub_rsltbuf
  import sif_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  localparam int CW = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             iss_req,
  output logic             iss_gnt,
  input  logic             R_vld,
  input  logic [WIDTH-1:0] R_dat,
  output logic             S_vld,
  output logic [WIDTH-1:0] S_dat,
  input  logic             S_rdy,
  output logic [CW-1:0]    occupancy,
  output logic [CW-1:0]    credits,
  output logic             ovf_err
);

  logic [CW-1:0] credits_q, credits_d;
  logic          ovf_err_q, ovf_err_d;
  logic          pop;
  logic          fifo_empty;
  logic          fifo_full;
  logic          fifo_ovf;

  sif_fifo_fwft #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (R_vld),
    .push_dat_i  (R_dat),
    .pop_i       (pop),
    .rd_dat_o    (S_dat),
    .occupancy_o (occupancy),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full),
    .ovf_o       (fifo_ovf)
  );

  assign S_vld = ~fifo_empty;
  assign pop   = S_vld & S_rdy;

  // credits_q resets to DEPTH, so the grant is also gated by rst_n itself.
  assign iss_gnt = rst_n & iss_req & (credits_q != '0);

  always_comb begin
    credits_d = credits_q;
    ovf_err_d = ovf_err_q | fifo_ovf;
    unique case ({iss_gnt, pop})
      2'b10:   credits_d = credits_q - CW'(1);
      2'b01:   if (credits_q != CW'(DEPTH)) credits_d = credits_q + CW'(1);
      default: credits_d = credits_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credits_q <= CW'(DEPTH);
      ovf_err_q <= 1'b0;
    end else begin
      credits_q <= credits_d;
      ovf_err_q <= ovf_err_d;
    end
  end

  assign credits = credits_q;
  assign ovf_err = ovf_err_q;

  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_sif_addsub_rsltbuf.sv
// tb/tb_sif_addsub_rsltbuf.sv - self-checking bench for sif_addsub_rsltbuf
module tb_sif_addsub_rsltbuf;

  localparam int WIDTH = 32;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             iss_req;
  logic             iss_gnt;
  logic             R_vld;
  logic [WIDTH-1:0] R_dat;
  logic             S_vld;
  logic [WIDTH-1:0] S_dat;
  logic             S_rdy;
  logic [CW-1:0]    occupancy;
  logic [CW-1:0]    credits;
  logic             ovf_err;

  sif_addsub_rsltbuf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .iss_req   (iss_req),
    .iss_gnt   (iss_gnt),
    .R_vld     (R_vld),
    .R_dat     (R_dat),
    .S_vld     (S_vld),
    .S_dat     (S_dat),
    .S_rdy     (S_rdy),
    .occupancy (occupancy),
    .credits   (credits),
    .ovf_err   (ovf_err)
  );

  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  // Reference model: queue of buffered results, credit pool, sticky overflow, ops in flight.
  int unsigned q[$];
  int          m_cred;
  bit          m_ovf;
  int          inflight;
  int          n_gnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_cred   = DEPTH;
    m_ovf    = 1'b0;
    inflight = 0;
  endtask

  // One clock: drive inputs, check outputs mid-cycle, advance, update the model.
  task automatic cycle(input bit req, input bit rv, input logic [31:0] rd, input bit rdy);
    bit g, p, acc;
    iss_req = req; R_vld = rv; R_dat = rd; S_rdy = rdy;
    #1;
    g = req && (m_cred > 0);
    p = (q.size() != 0) && rdy;
    chk("iss_gnt", iss_gnt, g);
    chk("S_vld", S_vld, q.size() != 0);
    if (q.size() != 0) chk("S_dat", S_dat, q[0]);
    chk("occupancy", occupancy, q.size());
    chk("credits", credits, m_cred);
    chk("ovf_err", ovf_err, m_ovf);
    if (iss_gnt) n_gnt++;
    @(posedge clk);
    acc = q.size() < DEPTH;
    if (rv && !acc) m_ovf = 1'b1;
    if (p) void'(q.pop_front());
    if (rv && acc) q.push_back(rd);
    m_cred = m_cred - int'(g) + int'(p);
    if (m_cred > DEPTH) m_cred = DEPTH;
    if (g) inflight++;
    if (rv && inflight > 0) inflight--;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; iss_req = 1'b1; R_vld = 1'b1; R_dat = 32'h55; S_rdy = 1'b0;
    model_reset();
    n_gnt = 0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_iss_gnt", iss_gnt, 1'b0);
    chk("rst_S_vld", S_vld, 1'b0);
    chk("rst_credits", credits, 16);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_ovf_err", ovf_err, 1'b0);
    rst_n = 1'b1;

    // Fill: 20 cycles of requests with the consumer stalled.
    for (int i = 0; i < 20; i++) cycle(1, 0, 0, 0);
    chk("fill_grants", n_gnt, 16);
    chk("fill_credits", credits, 0);
    for (int i = 1; i <= 16; i++) cycle(0, 1, i, 0);
    chk("fill_occupancy", occupancy, 16);
    chk("fill_ovf_err", ovf_err, 1'b0);

    // Drain with stalls, then continuously.
    for (int i = 0; i < 8; i++) cycle(0, 0, 0, (i % 2) == 0);
    for (int i = 0; i < 40 && q.size() != 0; i++) cycle(0, 0, 0, 1);
    chk("drain_credits", credits, 16);
    chk("drain_empty", S_vld, 1'b0);

    // Simultaneous grant and pop at credits=5, occupancy=3.
    for (int i = 0; i < 11; i++) cycle(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 1, 32'h200 + i, 0);
    chk("sim_pre_credits", credits, 5);
    chk("sim_pre_occupancy", occupancy, 3);
    cycle(1, 0, 0, 1);
    chk("sim_credits", credits, 5);
    chk("sim_occupancy", occupancy, 2);
    for (int i = 0; i < 20 && inflight > 0; i++) cycle(0, 1, 32'h300 + i, 1);
    for (int i = 0; i < 20 && q.size() != 0; i++) cycle(0, 0, 0, 1);
    chk("sim_restore_credits", credits, 16);

    // Wrap-around streaming at one result per cycle.
    for (int i = 0; i < 40; i++) begin
      cycle(1, 1, 32'h100 + i, 1);
      chk("wrap_occ_le1", occupancy <= 1, 1'b1);
    end
    cycle(0, 0, 0, 1);
    chk("wrap_credits", credits, 16);
    chk("wrap_occupancy", occupancy, 0);

    // Overflow injection.
    for (int i = 0; i < 16; i++) cycle(1, 0, 0, 0);
    for (int i = 0; i < 16; i++) cycle(0, 1, 32'h400 + i, 0);
    cycle(0, 1, 32'hDEAD, 0);
    chk("ovf_set", ovf_err, 1'b1);
    chk("ovf_occupancy", occupancy, 16);
    cycle(0, 1, 32'hBEEF, 1);
    chk("ovf_pushpop_occupancy", occupancy, 15);
    chk("ovf_pushpop_head", S_dat, 32'h401);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    chk("ovf_sticky", ovf_err, 1'b1);

    // Asynchronous reset mid-cycle.
    iss_req = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_iss_gnt", iss_gnt, 1'b0);
    chk("arst_S_vld", S_vld, 1'b0);
    chk("arst_credits", credits, 16);
    chk("arst_occupancy", occupancy, 0);
    chk("arst_ovf_err", ovf_err, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();

    // Randomized traffic honouring the credit contract.
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 1), (inflight > 0) && ($urandom_range(0, 1) == 1),
            $urandom, $urandom_range(0, 3) != 0);
      chk("invariant", occupancy + inflight + credits, DEPTH);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
